// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl
// Central stall/flush sequencer for the 5-stage IF/ID/EX/MEM/WB pipeline.
// Every pipeline-register enable, bubble and flush line is driven from here,
// so hazard stalls, memory waits, branch flushes and halt draining can never
// issue conflicting commands to the same stage.
//
// Ports:
//   clk           pipeline clock, rising edge
//   rst_n         asynchronous active-low reset
//   hazard_req    ID instruction reads a register still pending in EX/MEM/WB
//   mem_busy      data memory not ready, MEM stage must hold
//   branch_taken  branch resolved taken in ID
//   halt_req      stop fetching and drain the pipe
//   pc_en         PC update enable
//   ifid_en       IF/ID load enable
//   ifid_flush    load NOP into IF/ID
//   idex_en       ID/EX load enable
//   idex_bubble   load NOP into ID/EX
//   exmem_en      EX/MEM load enable
//   memwb_bubble  load NOP into MEM/WB
//   stall_active  registered: previous cycle was a hazard stall
//   halted        registered: pipeline drained and stopped
//   mem_err       registered, sticky: memory timeout occurred

module pipe_stall_ctrl #(
    parameter int MAX_HAZ_STALL = 3,
    parameter int MEM_TIMEOUT   = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic hazard_req,
    input  logic mem_busy,
    input  logic branch_taken,
    input  logic halt_req,
    output logic pc_en,
    output logic ifid_en,
    output logic ifid_flush,
    output logic idex_en,
    output logic idex_bubble,
    output logic exmem_en,
    output logic memwb_bubble,
    output logic stall_active,
    output logic halted,
    output logic mem_err
);

    localparam int HAZ_W = $clog2(MAX_HAZ_STALL + 1);
    localparam logic [HAZ_W-1:0] HAZ_MAX   = HAZ_W'(MAX_HAZ_STALL);
    localparam logic [7:0]       MEM_LIMIT = 8'(MEM_TIMEOUT);

    // The fourth non-frozen drain cycle (counting the one that accepted the
    // halt request as the first) moves the pipe to HALT.
    localparam logic [2:0] DRAIN_LAST = 3'd3;

    typedef enum logic [2:0] {
        RUN,
        HAZ,
        MWAIT,
        DRAIN,
        HALT
    } state_t;

    state_t           state, state_nxt;
    state_t           resume, resume_nxt;
    logic [HAZ_W-1:0] haz_cnt, haz_cnt_nxt;
    logic [7:0]       mem_cnt, mem_cnt_nxt;
    logic [2:0]       drain_cnt, drain_cnt_nxt;
    logic             stall_nxt;
    logic             err_nxt;

    logic pc_c, ifid_c, ifid_flush_c, idex_c, idex_bubble_c, exmem_c, memwb_bubble_c;

    // State and bookkeeping registers; reset returns straight to RUN from
    // anywhere, including HALT, which has no other exit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= RUN;
            resume       <= RUN;
            haz_cnt      <= '0;
            mem_cnt      <= '0;
            drain_cnt    <= '0;
            stall_active <= 1'b0;
            halted       <= 1'b0;
            mem_err      <= 1'b0;
        end else begin
            state        <= state_nxt;
            resume       <= resume_nxt;
            haz_cnt      <= haz_cnt_nxt;
            mem_cnt      <= mem_cnt_nxt;
            drain_cnt    <= drain_cnt_nxt;
            stall_active <= stall_nxt;
            halted       <= (state_nxt == HALT);
            mem_err      <= err_nxt;
        end
    end

    // Next-state and control-line decode. Memory freeze takes precedence
    // over everything because no stage may move while MEM is holding; the
    // hazard counter is left untouched across a freeze so frozen cycles do
    // not eat into the hazard-stall budget.
    always_comb begin
        state_nxt      = state;
        resume_nxt     = resume;
        haz_cnt_nxt    = haz_cnt;
        mem_cnt_nxt    = mem_cnt;
        drain_cnt_nxt  = drain_cnt;
        stall_nxt      = 1'b0;
        err_nxt        = mem_err;
        pc_c           = 1'b1;
        ifid_c         = 1'b1;
        ifid_flush_c   = 1'b0;
        idex_c         = 1'b1;
        idex_bubble_c  = 1'b0;
        exmem_c        = 1'b1;
        memwb_bubble_c = 1'b0;

        case (state)
            RUN, HAZ: begin
                if (mem_busy) begin
                    pc_c           = 1'b0;
                    ifid_c         = 1'b0;
                    idex_c         = 1'b0;
                    exmem_c        = 1'b0;
                    memwb_bubble_c = 1'b1;
                    resume_nxt     = state;
                    mem_cnt_nxt    = 8'd1;
                    if (MEM_LIMIT <= 8'd1) begin
                        err_nxt   = 1'b1;
                        state_nxt = HALT;
                    end else begin
                        state_nxt = MWAIT;
                    end
                end else if (hazard_req && (haz_cnt < HAZ_MAX)) begin
                    pc_c          = 1'b0;
                    ifid_c        = 1'b0;
                    idex_bubble_c = 1'b1;
                    haz_cnt_nxt   = haz_cnt + HAZ_W'(1);
                    stall_nxt     = 1'b1;
                    state_nxt     = HAZ;
                end else if (hazard_req) begin
                    // Writer has reached WB by now: let the instruction go.
                    haz_cnt_nxt = '0;
                    state_nxt   = RUN;
                end else if (branch_taken) begin
                    ifid_flush_c = 1'b1;
                    haz_cnt_nxt  = '0;
                    state_nxt    = RUN;
                end else if (halt_req) begin
                    pc_c          = 1'b0;
                    ifid_flush_c  = 1'b1;
                    drain_cnt_nxt = 3'd1;
                    haz_cnt_nxt   = '0;
                    state_nxt     = DRAIN;
                end else begin
                    haz_cnt_nxt = '0;
                    state_nxt   = RUN;
                end
            end

            MWAIT: begin
                if (mem_busy) begin
                    pc_c           = 1'b0;
                    ifid_c         = 1'b0;
                    idex_c         = 1'b0;
                    exmem_c        = 1'b0;
                    memwb_bubble_c = 1'b1;
                    mem_cnt_nxt    = mem_cnt + 8'd1;
                    if ((mem_cnt + 8'd1) >= MEM_LIMIT) begin
                        err_nxt   = 1'b1;
                        state_nxt = HALT;
                    end
                end else begin
                    mem_cnt_nxt = '0;
                    state_nxt   = resume;
                end
            end

            DRAIN: begin
                pc_c = 1'b0;
                if (mem_busy) begin
                    ifid_c         = 1'b0;
                    idex_c         = 1'b0;
                    exmem_c        = 1'b0;
                    memwb_bubble_c = 1'b1;
                end else begin
                    ifid_flush_c  = 1'b1;
                    drain_cnt_nxt = drain_cnt + 3'd1;
                    if (drain_cnt >= DRAIN_LAST) begin
                        state_nxt = HALT;
                    end
                end
            end

            HALT: begin
                pc_c           = 1'b0;
                ifid_c         = 1'b0;
                idex_c         = 1'b0;
                exmem_c        = 1'b0;
                memwb_bubble_c = 1'b1;
            end

            default: begin
                state_nxt = RUN;
            end
        endcase
    end

    // While reset is asserted nothing may load or be bubbled, independent of
    // whatever the inputs are doing.
    always_comb begin
        pc_en        = rst_n & pc_c;
        ifid_en      = rst_n & ifid_c;
        ifid_flush   = rst_n & ifid_flush_c;
        idex_en      = rst_n & idex_c;
        idex_bubble  = rst_n & idex_bubble_c;
        exmem_en     = rst_n & exmem_c;
        memwb_bubble = rst_n & memwb_bubble_c;
    end

endmodule

// File: doc/pipe_stall_ctrl.md
# pipe_stall_ctrl

- Central stall/flush sequencer for the 5-stage pipeline (IF, ID, EX, MEM, WB).
- Takes the hazard detector's raw dependency request, the data-memory busy flag, the ID-stage branch-taken signal and a halt request.
- Drives every pipeline-register enable, bubble and flush line from one place.
- Bounds hazard stalls with a counter, freezes the pipe on memory wait with a timeout, and drains the pipe on halt.

## Interface
- MAX_HAZ_STALL, 3: maximum consecutive hazard-stall cycles per ID instruction (no forwarding; writer reaches WB within 3 cycles).
- MEM_TIMEOUT, 15: consecutive mem_busy cycles after which mem_err is raised; range 1..255.
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- hazard_req  in  1  ID instruction reads a register pending in EX/MEM/WB.
- mem_busy  in  1  data memory not ready; MEM stage must hold.
- branch_taken  in  1  branch resolved taken in ID.
- halt_req  in  1  request to stop fetching and drain.
- pc_en  out  1  PC update enable.
- ifid_en  out  1  IF/ID register load enable.
- ifid_flush  out  1  load NOP into IF/ID.
- idex_en  out  1  ID/EX load enable.
- idex_bubble  out  1  load NOP into ID/EX.
- exmem_en  out  1  EX/MEM load enable.
- memwb_bubble  out  1  load NOP into MEM/WB.
- stall_active  out  1  registered; previous cycle was a hazard stall (fed back to hazard detector).
- halted  out  1  registered; pipeline drained and stopped.
- mem_err  out  1  registered, sticky; memory timeout occurred.

## Operation
- States: RUN, HAZ, MWAIT, DRAIN, HALT. Registers:
  - haz_cnt, width clog2(MAX_HAZ_STALL+1).
  - mem_cnt, 8 bits.
  - drain_cnt, 3 bits.
  - resume, which holds RUN or HAZ.
- Default outputs: all enables 1; bubble and flush lines 0.
- RUN/HAZ: evaluate the following per cycle, in priority order.
  1. mem_busy=1: freeze.
     - pc_en, ifid_en, idex_en and exmem_en are 0; memwb_bubble=1.
     - resume ← current state; next MWAIT; mem_cnt ← 1.
     - haz_cnt holds.
  2. hazard_req=1 and haz_cnt<MAX_HAZ_STALL: stall.
     - pc_en=0, ifid_en=0, idex_bubble=1.
     - haz_cnt++; next HAZ.
  3. hazard_req=1 and haz_cnt==MAX_HAZ_STALL: forced release.
     - Default outputs; haz_cnt ← 0; next RUN.
  4. branch_taken=1, only when hazard_req=0: ifid_flush=1; pc_en=1. A branch_taken with hazard_req=1 is ignored.
  5. halt_req=1, with hazard_req=0 and branch_taken=0: pc_en=0, ifid_flush=1; drain_cnt ← 1; next DRAIN.
  6. Otherwise: default outputs; haz_cnt ← 0; next RUN.
- MWAIT:
  - While mem_busy=1: outputs frozen as in rule 1; mem_cnt++.
  - If mem_cnt reaches MEM_TIMEOUT: mem_err ← 1; next HALT.
  - When mem_busy=0: default outputs; next resume; mem_cnt ← 0.
  - hazard_req, branch_taken and halt_req are not acted on while mem_busy=1.
- DRAIN:
  - pc_en=0, ifid_flush=1; other stages enabled.
  - hazard_req and branch_taken are ignored.
  - mem_busy freezes as in rule 1; drain_cnt holds and the state stays DRAIN.
  - drain_cnt increments on non-frozen cycles; after 4 non-frozen DRAIN cycles, next HALT.
- HALT:
  - pc_en, ifid_en, idex_en and exmem_en are 0; memwb_bubble=1; halted=1.
  - Exit only by reset.
- stall_active ← 1 on any edge closing a rule-2 cycle; otherwise 0.

## Timing
- Enable, bubble and flush outputs are combinational from inputs and registered state: zero-cycle response to hazard_req, mem_busy and branch_taken.
- All registers update on the rising clk edge; stall_active, halted and mem_err are valid one cycle after their cause.
- While rst_n=0:
  - pc_en, ifid_en, idex_en and exmem_en are forced to 0; bubbles and flush are 0.
  - State is RUN; haz_cnt, mem_cnt and drain_cnt are 0.
  - stall_active, halted and mem_err are 0.
- Reset mid-stall, mid-drain or in HALT returns to RUN immediately (asynchronous). First active edge after rst_n rises behaves as RUN.
- A hazard stall is never longer than MAX_HAZ_STALL active cycles.
- Memory-freeze cycles do not count toward the hazard limit.
- The halt path takes exactly 4 non-frozen DRAIN cycles, then HALT.

## Test plan
- **Hazard stall:** hazard_req=1 for 2 cycles, then 0.
  - pc_en=0, ifid_en=0, idex_bubble=1 for exactly 2 cycles.
  - stall_active=1 in cycles 2–3.
  - haz_cnt returns to 0.
- **Hazard limit:** hazard_req held high for 6 cycles.
  - 3 stall cycles, then 1 release cycle with default outputs, then 2 more stall cycles.
- **Memory wait over a stall:** mem_busy=1 during cycle 2 of a hazard stall, for 4 cycles.
  - Full freeze with memwb_bubble=1 for 4 cycles.
  - Then resume in HAZ with haz_cnt=1 still counted.
- **Branch vs. hazard:**
  - branch_taken=1 alone gives ifid_flush=1, pc_en=1.
  - branch_taken=1 with hazard_req=1 gives ifid_flush=0 and a stall.
- **Halt drain:** halt_req=1 in RUN.
  - pc_en=0, ifid_flush=1 for 4 cycles; a mem_busy pulse inside the drain extends it by the pulse length.
  - Then halted=1 and all enables 0.
- **Timeout and reset:** mem_busy held for 15 cycles (MEM_TIMEOUT=15).
  - mem_err=1 and HALT.
  - rst_n pulsed low mid-cycle clears mem_err, halted and state asynchronously.
